// File: rtl/fetch_sequencer.sv
// ---------------------------------------------------------------------------
// fetch_sequencer
// Program-counter controller for the 16-bit core's instruction fetch stage.
// Owns the 9-bit PC into the 512-word fetch memory, starts/stops fetch,
// applies branch/jump redirects with a flush window, honours stalls and
// detects the halt word returned by fetch.
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   asynchronous active-high reset
//   start      in   begin fetching (IDLE) or restart (HALT)
//   stall      in   hold PC this cycle
//   do_branch  in   taken branch, redirect to target
//   do_jump    in   jump, redirect to target
//   target     in   [8:0] redirect address
//   inst_valid in   fetch stage presents a live word
//   inst_word  in   [15:0] instruction word from fetch
//   pc         out  [8:0] current fetch address
//   fetch_en   out  pc is a live fetch request
//   flush      out  downstream stages discard in-flight instructions
//   halted     out  core halted
//   fault      out  pc ran off the end of memory
//
// Build option: define FETCH_BOUND_CHECK_EN to halt with fault=1 when the
// pc would advance past 511; otherwise the pc wraps to 0 and fault stays 0.
// ---------------------------------------------------------------------------
module fetch_sequencer #(
   parameter logic [8:0]  RESET_PC     = 9'd0,
   parameter int          FLUSH_CYCLES = 1,
   parameter logic [15:0] HALT_WORD    = 16'hFFFF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        stall,
   input  logic        do_branch,
   input  logic        do_jump,
   input  logic [8:0]  target,
   input  logic        inst_valid,
   input  logic [15:0] inst_word,
   output logic [8:0]  pc,
   output logic        fetch_en,
   output logic        flush,
   output logic        halted,
   output logic        fault
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_FLUSH = 2'd2,
      ST_HALT  = 2'd3
   } state_t;

   state_t      state_q, state_d;
   logic [8:0]  pc_q, pc_d;
   logic [2:0]  cnt_q, cnt_d;
   logic        fetch_en_q, fetch_en_d;
   logic        flush_q, flush_d;
   logic        halted_q, halted_d;
   logic        fault_q, fault_d;
   logic        redirect_s;
   logic        halt_hit_s;

   assign redirect_s = do_branch | do_jump;
   assign halt_hit_s = inst_valid && (inst_word == HALT_WORD);

   // State and output registers; reset forces the idle/reset values at once.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         pc_q       <= RESET_PC;
         cnt_q      <= 3'd0;
         fetch_en_q <= 1'b0;
         flush_q    <= 1'b0;
         halted_q   <= 1'b0;
         fault_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         cnt_q      <= cnt_d;
         fetch_en_q <= fetch_en_d;
         flush_q    <= flush_d;
         halted_q   <= halted_d;
         fault_q    <= fault_d;
      end
   end

   // Next-state and next-output logic.
   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      cnt_d      = cnt_q;
      fetch_en_d = fetch_en_q;
      flush_d    = 1'b0;
      halted_d   = halted_q;
      fault_d    = fault_q;

      case (state_q)
         ST_IDLE: begin
            pc_d       = RESET_PC;
            fetch_en_d = 1'b0;
            halted_d   = 1'b0;
            fault_d    = 1'b0;
            if (start) begin
               state_d    = ST_RUN;
               fetch_en_d = 1'b1;
            end else begin
               state_d = ST_IDLE;
            end
         end

         ST_RUN, ST_FLUSH: begin
            if (redirect_s) begin
               // Branch and jump together are one redirect; a redirect
               // inside FLUSH simply reloads the window.
               pc_d       = target;
               cnt_d      = 3'(FLUSH_CYCLES);
               state_d    = ST_FLUSH;
               flush_d    = 1'b1;
               fetch_en_d = 1'b1;
            end else if ((state_q == ST_RUN) && halt_hit_s) begin
               // One-cycle flush kills the word fetched behind the halt.
               state_d    = ST_HALT;
               halted_d   = 1'b1;
               fetch_en_d = 1'b0;
               flush_d    = 1'b1;
            end else begin
               // Flush window bookkeeping runs whether or not we stall.
               if (state_q == ST_FLUSH) begin
                  cnt_d = cnt_q - 3'd1;
                  if (cnt_q <= 3'd1) begin
                     state_d = ST_RUN;
                     flush_d = 1'b0;
                  end else begin
                     flush_d = 1'b1;
                  end
               end else begin
                  flush_d = 1'b0;
               end

               if (stall) begin
                  fetch_en_d = 1'b0;
               end else begin
`ifdef FETCH_BOUND_CHECK_EN
                  // Running off the end of memory is fatal: freeze at 511.
                  if (pc_q == 9'd511) begin
                     state_d    = ST_HALT;
                     halted_d   = 1'b1;
                     fault_d    = 1'b1;
                     fetch_en_d = 1'b0;
                     flush_d    = 1'b0;
                  end else begin
                     pc_d       = pc_q + 9'd1;
                     fetch_en_d = 1'b1;
                  end
`else
                  pc_d       = pc_q + 9'd1;
                  fetch_en_d = 1'b1;
                  fault_d    = 1'b0;
`endif
               end
            end
         end

         ST_HALT: begin
            fetch_en_d = 1'b0;
            if (start) begin
               state_d    = ST_RUN;
               pc_d       = RESET_PC;
               halted_d   = 1'b0;
               fault_d    = 1'b0;
               fetch_en_d = 1'b1;
            end else begin
               state_d = ST_HALT;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   assign pc       = pc_q;
   assign fetch_en = fetch_en_q;
   assign flush    = flush_q;
   assign halted   = halted_q;
   assign fault    = fault_q;

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Program-counter controller for the 16-bit core's instruction fetch stage. It owns the 9-bit PC driven into the 512-word fetch memory, starts and stops instruction fetch, applies branch/jump redirects with a configurable flush window, honours pipeline stalls, and detects the halt word returned by fetch. It sits between the hazard/branch logic and the fetch stage.

## Interface
Parameters:
- RESET_PC, 9'd0: PC loaded on reset and on restart from HALT.
- FLUSH_CYCLES, 1: cycles `flush` stays high after a redirect (range 1..7).
- HALT_WORD, 16'hFFFF: instruction encoding treated as halt.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  begin fetching (IDLE) or restart (HALT); level-sampled.
- stall  in  1  hold PC this cycle (hazard unit).
- do_branch  in  1  taken branch; redirect to `target`.
- do_jump  in  1  jump; redirect to `target`.
- target  in  9  redirect address.
- inst_valid  in  1  fetch stage presents a live word this cycle.
- inst_word  in  16  instruction word from fetch stage.
- pc  out  9  current fetch address.
- fetch_en  out  1  PC is a live fetch request this cycle.
- flush  out  1  downstream stages discard in-flight instructions.
- halted  out  1  core halted.
- fault  out  1  PC ran off the end of memory (see Configuration).

## Operation
- States: IDLE, RUN, FLUSH, HALT. Reset → IDLE.
- IDLE: pc=RESET_PC, fetch_en=0. start=1 → RUN.
- RUN/FLUSH, per cycle priority: redirect > halt detect > stall > advance.
  - Redirect (do_branch|do_jump): pc←target, flush counter←FLUSH_CYCLES, state→FLUSH. do_branch and do_jump together act as one redirect.
  - Halt detect (RUN only): inst_valid && inst_word==HALT_WORD → HALT, pc held, flush pulsed one cycle to kill the word fetched behind the halt.
  - Stall: pc held, fetch_en=0 for that cycle.
  - Advance: pc←pc+1, 9-bit modulo (511→0) unless bound check compiled in.
- FLUSH: flush=1, pc advances/stalls as in RUN, halt detect suppressed; counter decrements each cycle; at 0 → RUN. Redirect inside FLUSH reloads counter.
- HALT: halted=1, fetch_en=0, pc held; redirects and stall ignored. start=1 → RUN with pc←RESET_PC, halted←0, fault←0.
- Redirect, stall, inst_* ignored in IDLE.

## Timing
- All outputs registered. Reset values: pc=RESET_PC, fetch_en=0, flush=0, halted=0, fault=0; rst asserted mid-operation forces these immediately and returns to IDLE.
- start sampled at edge N in IDLE → fetch_en=1, pc=RESET_PC after edge N; pc=RESET_PC+1 after edge N+1 absent stall.
- Redirect sampled at edge N → pc=target and flush=1 after edge N; flush deasserts after edge N+FLUSH_CYCLES.
- Halt word sampled at edge N → halted=1, fetch_en=0, flush=1 after edge N; flush=0 after edge N+1.
- Stall is single-cycle granular: pc unchanged across every edge where stall=1.

## Configuration
- FETCH_BOUND_CHECK_EN defined: advancing from pc=9'd511 (no redirect) enters HALT with fault=1, halted=1, pc held at 511.
- Undefined: pc wraps 511→0 and continues; fault tied to 0.

## Test plan
- Reset, start pulse, no events → pc reads 0,1,2,3 on successive cycles, fetch_en=1 from first cycle after start.
- At pc=5, stall high 3 cycles → pc stays 5 for 3 cycles, fetch_en=0, then 6.
- FLUSH_CYCLES=2, do_branch with target=9'd23 at pc=10 → pc=23, flush high exactly 2 cycles, pc 24 next; second do_jump target=3 during flush → pc=3, flush restarts for 2 cycles.
- inst_valid with inst_word=16'hFFFF → halted=1, fetch_en=0, one-cycle flush, pc frozen; same word during FLUSH → no halt; start → pc=0, halted=0.
- Run to pc=511: with FETCH_BOUND_CHECK_EN → fault=1, halted=1; without → pc=0, fault=0.
- rst asserted mid-FLUSH and while halted → all outputs return to reset values asynchronously, state IDLE.
